bp_update_queue: RTL and testbench

- Buffers resolved branch outcomes from two branch-resolution requesters (slot 0 older than slot 1) and drains them in program order, one per cycle, into the branch predictor update interface.
- The predictor accepts at most one update per cycle and has no backpressure, so this block absorbs bursts, preserves ordering and discards pending updates on pipeline flush.
- Sits between the commit/branch-resolution stage and the predictor.

---
 rtl/bp_update_queue.sv | 119 +++++++++++
 tb/tb_bp_update_queue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bp_update_queue.sv
// Ordered queue of resolved branch outcomes from two resolution slots, drained one per cycle to the predictor.
// Optional counters are built when BP_UPD_STATS_EN is defined; otherwise the stat ports are tied to zero.
module bp_update_queue #(
    parameter int PC_WIDTH = 32,
    parameter int DEPTH    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [PC_WIDTH-1:0] req0_pc,
    input  logic                req0_taken,
    input  logic [PC_WIDTH-1:0] req0_target,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [PC_WIDTH-1:0] req1_pc,
    input  logic                req1_taken,
    input  logic [PC_WIDTH-1:0] req1_target,
    output logic                update_valid,
    output logic [PC_WIDTH-1:0] update_pc,
    output logic                update_taken,
    output logic [PC_WIDTH-1:0] update_target,
    output logic [31:0]         stat_updates,
    output logic [31:0]         stat_taken,
    output logic [31:0]         stat_full_cycles
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] LIM0 = CW'(DEPTH - 1);
    localparam logic [CW-1:0] LIM1 = CW'(DEPTH - 2);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PC_WIDTH-1:0] pc_q     [DEPTH];
    logic [PC_WIDTH-1:0] target_q [DEPTH];
    logic [DEPTH-1:0]    taken_q;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr1_idx;
    logic          push0, push1, pop;

    // Ready looks only at the registered count, so a same-cycle pop never frees space.
    assign req0_ready   = !reset && !flush && (count_q <= LIM0);
    assign req1_ready   = !reset && !flush && (count_q <= LIM1);
    assign update_valid = !reset && !flush && (count_q != '0);

    assign update_pc     = pc_q[head_q];
    assign update_taken  = taken_q[head_q];
    assign update_target = target_q[head_q];

    always_comb begin
        push0   = req0_valid && req0_ready;
        push1   = req1_valid && req1_ready;
        pop     = update_valid;
        wr1_idx = push0 ? tail_q + PW'(1) : tail_q;
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(push0) + PW'(push1);
        count_d = count_q + CW'(push0) + CW'(push1) - CW'(pop);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (push0) begin
            pc_q[tail_q]     <= req0_pc;
            taken_q[tail_q]  <= req0_taken;
            target_q[tail_q] <= req0_target;
        end
        if (push1) begin
            pc_q[wr1_idx]     <= req1_pc;
            taken_q[wr1_idx]  <= req1_taken;
            target_q[wr1_idx] <= req1_target;
        end
    end

`ifdef BP_UPD_STATS_EN
    logic [31:0] stat_upd_q, stat_tkn_q, stat_full_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_upd_q  <= '0;
            stat_tkn_q  <= '0;
            stat_full_q <= '0;
        end else begin
            if (pop) stat_upd_q <= stat_upd_q + 32'd1;
            if (pop && update_taken) stat_tkn_q <= stat_tkn_q + 32'd1;
            if (count_q == FULL) stat_full_q <= stat_full_q + 32'd1;
        end
    end

    assign stat_updates     = reset ? '0 : stat_upd_q;
    assign stat_taken       = reset ? '0 : stat_tkn_q;
    assign stat_full_cycles = reset ? '0 : stat_full_q;
`else
    assign stat_updates     = '0;
    assign stat_taken       = '0;
    assign stat_full_cycles = '0;
`endif

endmodule

// File: tb/tb_bp_update_queue.sv
// Directed bench: a cycle table on a DEPTH=4 queue, plus a DEPTH=2 sequence that reaches full and checks the counters.
module tb_bp_update_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=4 instance (table driven)
    logic        a_reset, a_flush, a_v0, a_t0, a_v1, a_t1;
    logic [31:0] a_pc0, a_tg0, a_pc1, a_tg1;
    logic        a_r0, a_r1, a_uv, a_ut;
    logic [31:0] a_upc, a_utg, a_su, a_st, a_sf;

    // DEPTH=2 instance (full and counter sequence)
    logic        b_reset, b_flush, b_v0, b_t0, b_v1, b_t1;
    logic [31:0] b_pc0, b_tg0, b_pc1, b_tg1;
    logic        b_r0, b_r1, b_uv, b_ut;
    logic [31:0] b_upc, b_utg, b_su, b_st, b_sf;

    bp_update_queue #(.PC_WIDTH(32), .DEPTH(4)) dut_a (
        .clk(clk), .reset(a_reset), .flush(a_flush),
        .req0_valid(a_v0), .req0_ready(a_r0), .req0_pc(a_pc0), .req0_taken(a_t0), .req0_target(a_tg0),
        .req1_valid(a_v1), .req1_ready(a_r1), .req1_pc(a_pc1), .req1_taken(a_t1), .req1_target(a_tg1),
        .update_valid(a_uv), .update_pc(a_upc), .update_taken(a_ut), .update_target(a_utg),
        .stat_updates(a_su), .stat_taken(a_st), .stat_full_cycles(a_sf)
    );

    bp_update_queue #(.PC_WIDTH(32), .DEPTH(2)) dut_b (
        .clk(clk), .reset(b_reset), .flush(b_flush),
        .req0_valid(b_v0), .req0_ready(b_r0), .req0_pc(b_pc0), .req0_taken(b_t0), .req0_target(b_tg0),
        .req1_valid(b_v1), .req1_ready(b_r1), .req1_pc(b_pc1), .req1_taken(b_t1), .req1_target(b_tg1),
        .update_valid(b_uv), .update_pc(b_upc), .update_taken(b_ut), .update_target(b_utg),
        .stat_updates(b_su), .stat_taken(b_st), .stat_full_cycles(b_sf)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Every target is pc + 0x100 so the expected target follows from the expected pc.
    typedef struct {
        logic        rst, fl, v0;
        logic [31:0] pc0;
        logic        t0, v1;
        logic [31:0] pc1;
        logic        t1, uv;
        logic [31:0] upc;
        logic        ut, r0, r1;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic fl,
                                input logic v0, input logic [31:0] pc0, input logic t0,
                                input logic v1, input logic [31:0] pc1, input logic t1,
                                input logic uv, input logic [31:0] upc, input logic ut,
                                input logic r0, input logic r1);
        vec_t v;
        v.rst = rst; v.fl = fl; v.v0 = v0; v.pc0 = pc0; v.t0 = t0;
        v.v1 = v1; v.pc1 = pc1; v.t1 = t1; v.uv = uv; v.upc = upc; v.ut = ut;
        v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    task automatic drive_b(input logic rst, input logic fl,
                           input logic v0, input logic [31:0] pc0, input logic t0,
                           input logic v1, input logic [31:0] pc1, input logic t1);
        b_reset = rst; b_flush = fl;
        b_v0 = v0; b_pc0 = pc0; b_t0 = t0; b_tg0 = pc0 + 32'h100;
        b_v1 = v1; b_pc1 = pc1; b_t1 = t1; b_tg1 = pc1 + 32'h100;
    endtask

    task automatic chk_b(input string tag, input logic uv, input logic [31:0] upc, input logic ut,
                         input logic r0, input logic r1);
        chk({tag, " update_valid"}, {31'd0, b_uv}, {31'd0, uv});
        chk({tag, " req0_ready"}, {31'd0, b_r0}, {31'd0, r0});
        chk({tag, " req1_ready"}, {31'd0, b_r1}, {31'd0, r1});
        if (uv) begin
            chk({tag, " update_pc"}, b_upc, upc);
            chk({tag, " update_taken"}, {31'd0, b_ut}, {31'd0, ut});
            chk({tag, " update_target"}, b_utg, upc + 32'h100);
        end
    endtask

    vec_t tbl[$];
    logic [31:0] exp_su, exp_st, exp_sf;

    initial begin
        a_reset = 1'b1; a_flush = 1'b0; a_v0 = 1'b0; a_t0 = 1'b0; a_v1 = 1'b0; a_t1 = 1'b0;
        a_pc0 = '0; a_tg0 = '0; a_pc1 = '0; a_tg1 = '0;
        drive_b(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

        //                rst fl  v0  pc0      t0  v1  pc1      t1  uv  upc      ut  r0  r1
        tbl.push_back(mk(1, 0,  1, 32'h999, 0,  0, 32'h0,   0,  0, 32'h0,   0,  0,  0)); // reset blocks ready
        tbl.push_back(mk(0, 0,  0, 32'h0,   0,  0, 32'h0,   0,  0, 32'h0,   0,  1,  1));
        tbl.push_back(mk(0, 0,  1, 32'h100, 1,  0, 32'h0,   0,  0, 32'h0,   0,  1,  1)); // single push, no bypass
        tbl.push_back(mk(0, 0,  0, 32'h0,   0,  0, 32'h0,   0,  1, 32'h100, 1,  1,  1));
        tbl.push_back(mk(0, 0,  0, 32'h0,   0,  0, 32'h0,   0,  0, 32'h0,   0,  1,  1));
        tbl.push_back(mk(0, 0,  1, 32'h10,  0,  1, 32'h20,  1,  0, 32'h0,   0,  1,  1)); // dual push order
        tbl.push_back(mk(0, 0,  0, 32'h0,   0,  0, 32'h0,   0,  1, 32'h10,  0,  1,  1));
        tbl.push_back(mk(0, 0,  0, 32'h0,   0,  0, 32'h0,   0,  1, 32'h20,  1,  1,  1));
        tbl.push_back(mk(0, 0,  0, 32'h0,   0,  0, 32'h0,   0,  0, 32'h0,   0,  1,  1));
        tbl.push_back(mk(0, 0,  1, 32'h31,  1,  1, 32'h32,  0,  0, 32'h0,   0,  1,  1)); // fill, pointers wrap
        tbl.push_back(mk(0, 0,  1, 32'h33,  0,  1, 32'h34,  1,  1, 32'h31,  1,  1,  1));
        tbl.push_back(mk(0, 0,  1, 32'h35,  1,  1, 32'h36,  0,  1, 32'h32,  0,  1,  0));
        tbl.push_back(mk(0, 0,  0, 32'h0,   0,  1, 32'h36,  0,  1, 32'h33,  0,  1,  0));
        tbl.push_back(mk(0, 0,  0, 32'h0,   0,  1, 32'h36,  0,  1, 32'h34,  1,  1,  1));
        tbl.push_back(mk(0, 0,  0, 32'h0,   0,  0, 32'h0,   0,  1, 32'h35,  1,  1,  1));
        tbl.push_back(mk(0, 0,  0, 32'h0,   0,  0, 32'h0,   0,  1, 32'h36,  0,  1,  1));
        tbl.push_back(mk(0, 0,  0, 32'h0,   0,  0, 32'h0,   0,  0, 32'h0,   0,  1,  1));
        tbl.push_back(mk(0, 0,  1, 32'h41,  1,  1, 32'h42,  1,  0, 32'h0,   0,  1,  1)); // build count=3
        tbl.push_back(mk(0, 0,  1, 32'h43,  0,  1, 32'h44,  0,  1, 32'h41,  1,  1,  1));
        tbl.push_back(mk(0, 1,  1, 32'h45,  1,  0, 32'h0,   0,  0, 32'h0,   0,  0,  0)); // flush
        tbl.push_back(mk(0, 0,  0, 32'h0,   0,  0, 32'h0,   0,  0, 32'h0,   0,  1,  1));
        tbl.push_back(mk(0, 0,  1, 32'h51,  1,  1, 32'h52,  1,  0, 32'h0,   0,  1,  1)); // count=2 then reset
        tbl.push_back(mk(1, 0,  0, 32'h0,   0,  0, 32'h0,   0,  0, 32'h0,   0,  0,  0));
        tbl.push_back(mk(0, 0,  0, 32'h0,   0,  0, 32'h0,   0,  0, 32'h0,   0,  1,  1));
        tbl.push_back(mk(0, 0,  1, 32'h61,  0,  0, 32'h0,   0,  0, 32'h0,   0,  1,  1));
        tbl.push_back(mk(0, 0,  0, 32'h0,   0,  0, 32'h0,   0,  1, 32'h61,  0,  1,  1));
        tbl.push_back(mk(0, 0,  0, 32'h0,   0,  0, 32'h0,   0,  0, 32'h0,   0,  1,  1));

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            a_reset = tbl[i].rst; a_flush = tbl[i].fl;
            a_v0 = tbl[i].v0; a_pc0 = tbl[i].pc0; a_t0 = tbl[i].t0; a_tg0 = tbl[i].pc0 + 32'h100;
            a_v1 = tbl[i].v1; a_pc1 = tbl[i].pc1; a_t1 = tbl[i].t1; a_tg1 = tbl[i].pc1 + 32'h100;
            @(negedge clk);
            chk($sformatf("row%0d update_valid", i), {31'd0, a_uv}, {31'd0, tbl[i].uv});
            chk($sformatf("row%0d req0_ready", i), {31'd0, a_r0}, {31'd0, tbl[i].r0});
            chk($sformatf("row%0d req1_ready", i), {31'd0, a_r1}, {31'd0, tbl[i].r1});
            if (tbl[i].uv) begin
                chk($sformatf("row%0d update_pc", i), a_upc, tbl[i].upc);
                chk($sformatf("row%0d update_taken", i), {31'd0, a_ut}, {31'd0, tbl[i].ut});
                chk($sformatf("row%0d update_target", i), a_utg, tbl[i].upc + 32'h100);
            end
            if (tbl[i].rst) begin
                chk($sformatf("row%0d stat_updates", i), a_su, 32'h0);
                chk($sformatf("row%0d stat_full_cycles", i), a_sf, 32'h0);
            end
        end

        // DEPTH=2: reach full once, issue 5 updates of which 3 are taken.
`ifdef BP_UPD_STATS_EN
        exp_su = 32'd5; exp_st = 32'd3; exp_sf = 32'd1;
`else
        exp_su = 32'd0; exp_st = 32'd0; exp_sf = 32'd0;
`endif
        @(posedge clk); #1;
        drive_b(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk_b("b_reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("b_reset stat_updates", b_su, 32'h0);
        chk("b_reset stat_taken", b_st, 32'h0);
        chk("b_reset stat_full_cycles", b_sf, 32'h0);

        @(posedge clk); #1; drive_b(1'b0, 1'b0, 1'b1, 32'h71, 1'b1, 1'b1, 32'h72, 1'b0);
        @(negedge clk); chk_b("b_c0", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1; drive_b(1'b0, 1'b0, 1'b1, 32'h73, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk); chk_b("b_full", 1'b1, 32'h71, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1; drive_b(1'b0, 1'b0, 1'b1, 32'h73, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk); chk_b("b_c2", 1'b1, 32'h72, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1; drive_b(1'b0, 1'b0, 1'b1, 32'h74, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk); chk_b("b_c3", 1'b1, 32'h73, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1; drive_b(1'b0, 1'b0, 1'b1, 32'h75, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk); chk_b("b_c4", 1'b1, 32'h74, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1; drive_b(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk); chk_b("b_c5", 1'b1, 32'h75, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(negedge clk); chk_b("b_c6", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("stat_updates", b_su, exp_su);
        chk("stat_taken", b_st, exp_st);
        chk("stat_full_cycles", b_sf, exp_sf);

        // Flush must leave the counters alone.
        @(posedge clk); #1; drive_b(1'b0, 1'b1, 1'b1, 32'h76, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk); chk_b("b_flush", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1; drive_b(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk); chk_b("b_post_flush", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("post_flush stat_updates", b_su, exp_su);
        chk("post_flush stat_taken", b_st, exp_st);
        chk("post_flush stat_full_cycles", b_sf, exp_sf);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
